const_sub_stage: RTL and testbench

CONST_SUB_STAGE -- requirements
Module: const_sub_stage

---
 rtl/ascon_pkg.sv | 27 ++
 rtl/substitution_layer.sv | 28 ++
 rtl/const_sub_stage.sv | 140 ++++++++++++++
 tb/tb_const_sub_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants for the permutation datapath.
package ascon_pkg;

  localparam int WORD_WIDTH     = 64;
  localparam int NUM_WORDS      = 5;
  localparam int ROUNDS_MAX     = 12;
  localparam int CONST_IDX_LAST = 15;

  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
  typedef logic [3:0] round_idx_t;

  localparam logic [7:0] ROUND_CONST [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef struct packed {
    ascon_state_t state;
    round_idx_t   idx;
    logic         last;
  } beat_t;

  function automatic logic [7:0] round_const(input round_idx_t idx);
    return ROUND_CONST[idx];
  endfunction

endpackage

// File: rtl/substitution_layer.sv
// Combinational Ascon 5-bit S-box applied bitsliced across all 64 columns.
module substitution_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  logic [WORD_WIDTH-1:0] w_x [NUM_WORDS];
  logic [WORD_WIDTH-1:0] w_t [NUM_WORDS];
  logic [WORD_WIDTH-1:0] w_y [NUM_WORDS];

  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) w_x[i] = state_i[i];
    w_x[0] = w_x[0] ^ w_x[4];
    w_x[4] = w_x[4] ^ w_x[3];
    w_x[2] = w_x[2] ^ w_x[1];
    // chi-like nonlinear step, then the output linear fix-up
    for (int i = 0; i < NUM_WORDS; i++) w_t[i] = ~w_x[i] & w_x[(i + 1) % NUM_WORDS];
    for (int i = 0; i < NUM_WORDS; i++) w_y[i] = w_x[i] ^ w_t[(i + 1) % NUM_WORDS];
    w_y[1] = w_y[1] ^ w_y[0];
    w_y[0] = w_y[0] ^ w_y[4];
    w_y[3] = w_y[3] ^ w_y[2];
    w_y[2] = ~w_y[2];
    for (int i = 0; i < NUM_WORDS; i++) state_o[i] = w_y[i];
  end

endmodule

// File: rtl/const_sub_stage.sv
// Ascon round front half: round-constant addition plus S-box, one registered stage.
// Define ASCON_CONST_SUB_SKID_EN for a 2-entry skid buffer with a registered in_ready_o.
module const_sub_stage
  import ascon_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  ascon_state_t state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_o,
  output logic [3:0]   round_idx_o,
  output logic         last_o,
  output logic         err_o
);

  logic         w_push;
  round_idx_t   w_idx;
  logic         w_err_set;
  logic         w_err_clr;
  ascon_state_t w_state_ca;
  ascon_state_t w_state_sb;
  beat_t        w_beat;
  beat_t        w_out;
  logic         w_out_vld;

  logic         r_active;
  round_idx_t   r_seq_idx;
  logic         r_err;

  assign w_push = in_valid_i && in_ready_o;

  // Bad rounds fall back to a full 12-round run; stray continuations pin to the last index.
  always_comb begin
    w_idx     = r_seq_idx + 4'd1;
    w_err_set = 1'b0;
    w_err_clr = 1'b0;
    if (start_i) begin
      if (rounds_i == 4'd0 || rounds_i > 4'(ROUNDS_MAX)) begin
        w_idx     = 4'(16 - ROUNDS_MAX);
        w_err_set = 1'b1;
      end else begin
        w_idx     = 4'd0 - rounds_i;
        w_err_clr = 1'b1;
      end
    end else if (!r_active || r_seq_idx == 4'(CONST_IDX_LAST)) begin
      w_idx     = 4'(CONST_IDX_LAST);
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active  <= 1'b0;
      r_seq_idx <= '0;
      r_err     <= 1'b0;
    end else if (w_push) begin
      r_active  <= 1'b1;
      r_seq_idx <= w_idx;
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  always_comb begin
    w_state_ca       = state_i;
    w_state_ca[2][7:0] = state_i[2][7:0] ^ round_const(w_idx);
  end

  substitution_layer u_sbox (
    .state_i (w_state_ca),
    .state_o (w_state_sb)
  );

  assign w_beat = '{state: w_state_sb, idx: w_idx, last: (w_idx == 4'(CONST_IDX_LAST))};

`ifdef ASCON_CONST_SUB_SKID_EN
  // r_buf[0] drives the outputs; entries 1 and 2 absorb beats accepted during a stall.
  beat_t      r_buf [3];
  logic [1:0] r_cnt;
  logic       r_in_rdy;
  logic       w_pop;
  logic [1:0] w_wr;
  logic [1:0] w_cnt_nxt;

  assign w_pop     = (r_cnt != 2'd0) && out_ready_i;
  assign w_wr      = r_cnt - {1'b0, w_pop};
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= 2'd0;
      r_in_rdy <= 1'b0;
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < 2; i++) r_buf[i] <= r_buf[i+1];
      end
      if (w_push) r_buf[w_wr] <= w_beat;
      r_cnt    <= w_cnt_nxt;
      r_in_rdy <= (w_cnt_nxt != 2'd3);
    end
  end

  assign in_ready_o = r_in_rdy;
  assign w_out      = r_buf[0];
  assign w_out_vld  = (r_cnt != 2'd0);
`else
  beat_t r_out;
  logic  r_out_vld;

  assign in_ready_o = rst_ni && (!r_out_vld || out_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (w_push) begin
      r_out_vld <= 1'b1;
      r_out     <= w_beat;
    end else if (out_ready_i) begin
      r_out_vld <= 1'b0;
    end
  end

  assign w_out     = r_out;
  assign w_out_vld = r_out_vld;
`endif

  assign out_valid_o = w_out_vld;
  assign state_o     = w_out.state;
  assign round_idx_o = w_out.idx;
  assign last_o      = w_out.last;
  assign err_o       = r_err;

endmodule

// File: tb/tb_const_sub_stage.sv
// Directed bench for const_sub_stage with an independent table-driven S-box reference.
module tb_const_sub_stage;
  import ascon_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic         start_i = 1'b0;
  logic [3:0]   rounds_i = 4'd0;
  ascon_state_t state_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  ascon_state_t state_o;
  logic [3:0]   round_idx_o;
  logic         last_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ASCON_CONST_SUB_SKID_EN
  localparam int EXP_ABSORB = 2;
`else
  localparam int EXP_ABSORB = 0;
`endif

  localparam logic [7:0] RC [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  const_sub_stage dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .start_i     (start_i),
    .rounds_i    (rounds_i),
    .state_i     (state_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .round_idx_o (round_idx_o),
    .last_o      (last_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic ascon_state_t ref_round(input ascon_state_t s, input logic [3:0] idx);
    ascon_state_t r;
    logic [4:0]   col;
    logic [4:0]   o;
    s[2][7:0] = s[2][7:0] ^ RC[idx];
    for (int c = 0; c < 64; c++) begin
      col = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
      o   = SBOX[col];
      r[0][c] = o[4]; r[1][c] = o[3]; r[2][c] = o[2]; r[3][c] = o[1]; r[4][c] = o[0];
    end
    return r;
  endfunction

  function automatic ascon_state_t pat(input int k);
    ascon_state_t s;
    for (int i = 0; i < 5; i++) s[i] = 64'h9E3779B97F4A7C15 * 64'(k * 5 + i + 1);
    return s;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [3:0] r,
                       input ascon_state_t st, input logic ordy);
    @(negedge clk_i);
    in_valid_i = v; start_i = s; rounds_i = r; state_i = st; out_ready_i = ordy;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o, in_ready_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async_ctl: got %b required 00000000",
               {out_valid_o, round_idx_o, last_o, err_o, in_ready_o});
    end
    drive(1'b1, 1'b1, 4'd12, pat(1), 1'b1);
    drive(1'b1, 1'b0, 4'd0, pat(2), 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o, in_ready_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held_ctl: got %b required 00000000",
               {out_valid_o, round_idx_o, last_o, err_o, in_ready_o});
    end
    n_tests++;
    if (state_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required 0", state_o);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
  endtask

  task automatic test_zero_state();
    drive(1'b1, 1'b1, 4'd12, '0, 1'b1);
    n_tests++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_in_ready: got %b required 1", in_ready_o);
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o} !== {1'b1, 4'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_ctl: got %b required 1010000", {out_valid_o, round_idx_o, last_o, err_o});
    end
    n_tests++;
    if (state_o !== {64'h0, 64'hF0, 64'hFFFF_FFFF_FFFF_FF0F, 64'hF0, 64'hF0}) begin
      n_fail++;
      $display("FAIL zero_state: got %h required S0=S1=S3=f0 S2=ffffffffffffff0f S4=0", state_o);
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    n_tests++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_drain: out_valid got %b required 0", out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_idx;
    for (int k = 0; k <= 8; k++) begin
      drive(k < 8, k == 0, 4'd8, pat(10 + k), 1'b1);
      if (k < 8) begin
        n_tests++;
        if (in_ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready beat %0d: got %b required 1", k, in_ready_o);
        end
      end
      if (k > 0) begin
        e_idx = 4'(8 + k - 1);
        n_tests++;
        if ({out_valid_o, round_idx_o, last_o, err_o} !== {1'b1, e_idx, e_idx == 4'd15, 1'b0}) begin
          n_fail++;
          $display("FAIL b2b_ctl beat %0d: got %b required %b", k - 1,
                   {out_valid_o, round_idx_o, last_o, err_o}, {1'b1, e_idx, e_idx == 4'd15, 1'b0});
        end
        n_tests++;
        if (state_o !== ref_round(pat(10 + k - 1), e_idx)) begin
          n_fail++;
          $display("FAIL b2b_state beat %0d: got %h required %h", k - 1, state_o,
                   ref_round(pat(10 + k - 1), e_idx));
        end
      end
    end
  endtask

  task automatic test_errors();
    drive(1'b1, 1'b0, 4'd0, pat(20), 1'b1);
    drive(1'b1, 1'b0, 4'd0, pat(21), 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o} !== {1'b1, 4'd15, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL err_ninth_ctl: got %b required 1111111", {out_valid_o, round_idx_o, last_o, err_o});
    end
    n_tests++;
    if (state_o !== ref_round(pat(20), 4'd15)) begin
      n_fail++;
      $display("FAIL err_ninth_state: got %h required %h", state_o, ref_round(pat(20), 4'd15));
    end
    drive(1'b1, 1'b1, 4'd8, pat(22), 1'b1);
    n_tests++;
    if ({round_idx_o, last_o, err_o} !== {4'd15, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL err_repeat_ctl: got %b required 111111", {round_idx_o, last_o, err_o});
    end
    drive(1'b1, 1'b1, 4'd0, pat(23), 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o} !== {1'b1, 4'd8, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_clear_ctl: got %b required 1100000", {out_valid_o, round_idx_o, last_o, err_o});
    end
    drive(1'b1, 1'b0, 4'd0, pat(24), 1'b1);
    n_tests++;
    if ({round_idx_o, err_o} !== {4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL err_rounds0: got idx %0d err %b required idx 4 err 1", round_idx_o, err_o);
    end
    n_tests++;
    if (state_o !== ref_round(pat(23), 4'd4)) begin
      n_fail++;
      $display("FAIL err_rounds0_state: got %h required %h", state_o, ref_round(pat(23), 4'd4));
    end
    drive(1'b1, 1'b1, 4'd13, pat(25), 1'b1);
    n_tests++;
    if ({round_idx_o, err_o} !== {4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL err_sticky: got idx %0d err %b required idx 5 err 1", round_idx_o, err_o);
    end
    drive(1'b1, 1'b1, 4'd3, pat(26), 1'b1);
    n_tests++;
    if ({round_idx_o, err_o} !== {4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL err_rounds13: got idx %0d err %b required idx 4 err 1", round_idx_o, err_o);
    end
    drive(1'b1, 1'b1, 4'd10, pat(27), 1'b1);
    n_tests++;
    if ({round_idx_o, err_o} !== {4'd13, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_first: got idx %0d err %b required idx 13 err 0", round_idx_o, err_o);
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, err_o} !== {1'b1, 4'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_mid: got vld %b idx %0d err %b required vld 1 idx 6 err 0",
               out_valid_o, round_idx_o, err_o);
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
  endtask

  task automatic test_stall();
    int n_acc;
    drive(1'b1, 1'b1, 4'd8, pat(40), 1'b1);
    n_acc = 1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 4'd0, pat(40 + n_acc), 1'b0);
      n_tests++;
      if ({out_valid_o, round_idx_o} !== {1'b1, 4'd8} || state_o !== ref_round(pat(40), 4'd8)) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got vld %b idx %0d required vld 1 idx 8 with beat-0 state",
                 c, out_valid_o, round_idx_o);
      end
      if (in_ready_o) n_acc++;
    end
    n_tests++;
    if (n_acc - 1 != EXP_ABSORB) begin
      n_fail++;
      $display("FAIL stall_absorb: got %0d beats required %0d", n_acc - 1, EXP_ABSORB);
    end
    for (int j = 0; j < n_acc; j++) begin
      drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
      n_tests++;
      if ({out_valid_o, round_idx_o} !== {1'b1, 4'(8 + j)} ||
          state_o !== ref_round(pat(40 + j), 4'(8 + j))) begin
        n_fail++;
        $display("FAIL stall_drain beat %0d: got vld %b idx %0d required vld 1 idx %0d",
                 j, out_valid_o, round_idx_o, 8 + j);
      end
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    n_tests++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_dup: out_valid got %b required 0", out_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 4'd6, pat(50), 1'b1);
    drive(1'b0, 1'b0, 4'd0, '0, 1'b0);
    n_tests++;
    if ({out_valid_o, round_idx_o} !== {1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got vld %b idx %0d required vld 1 idx 10", out_valid_o, round_idx_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o, in_ready_o} !== 8'h00 || state_o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got ctl %b state %h required all zero",
               {out_valid_o, round_idx_o, last_o, err_o, in_ready_o}, state_o);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    drive(1'b1, 1'b0, 4'd0, pat(51), 1'b1);
    drive(1'b1, 1'b1, 4'd12, pat(52), 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o} !== {1'b1, 4'd15, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_nostart: got %b required 1111111", {out_valid_o, round_idx_o, last_o, err_o});
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
    n_tests++;
    if ({out_valid_o, round_idx_o, last_o, err_o} !== {1'b1, 4'd4, 1'b0, 1'b0} ||
        state_o !== ref_round(pat(52), 4'd4)) begin
      n_fail++;
      $display("FAIL rstmid_start12: got %b required 1010000", {out_valid_o, round_idx_o, last_o, err_o});
    end
    drive(1'b0, 1'b0, 4'd0, '0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_back_to_back();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
